// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: computes A - B - bin, DIGIT bits per cycle, LSB first.
// Y/borrow are registered and only change when an operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             borrow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dig_full;
    logic [WIDTH-1:0] res_next;

    // The extra top bit of dig_full is the borrow out of the current digit.
    always_comb begin
        a_dig    = a_q[int'(cnt_q) * DIGIT +: DIGIT];
        b_dig    = b_q[int'(cnt_q) * DIGIT +: DIGIT];
        dig_full = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, br_q};
        res_next = res_q;
        res_next[int'(cnt_q) * DIGIT +: DIGIT] = dig_full[DIGIT-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        res_d    = res_q;
        y_d      = y_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = done_q;
        if (en) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_d     = A;
                        b_d     = B;
                        br_d    = bin;
                        cnt_d   = '0;
                        res_d   = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    res_d = res_next;
                    br_d  = dig_full[DIGIT];
                    cnt_d = cnt_q + 1'b1;
                    // Last digit: publish the result and free the unit in the same edge.
                    if (cnt_q == LAST) begin
                        y_d      = res_next;
                        borrow_d = dig_full[DIGIT];
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            res_q    <= '0;
            y_q      <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            res_q    <= res_d;
            y_q      <= y_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Y      = y_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit/2-bit-digit instance and a 1-bit instance.
// Stimulus pushes hand-computed results; monitors pop and compare on each done pulse.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] y;
        logic       br;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] y;
        logic       br;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a     = 8'h00;
    logic [7:0] b     = 8'h00;
    logic       bin   = 1'b0;
    logic       busy, done, borrow;
    logic [7:0] y;

    logic       start1 = 1'b0;
    logic [0:0] a1     = 1'b0;
    logic [0:0] b1     = 1'b0;
    logic       busy1, done1, borrow1;
    logic [0:0] y1;

    exp_t exp_q[$];
    exp_t exp1_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_done  = 1'b0;
    logic prev_done1 = 1'b0;
    exp_t mon_e;
    exp_t mon_e1;

    serial_subtractor #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .A(a), .B(b), .bin(bin),
        .busy(busy), .done(done), .Y(y), .borrow(borrow)
    );

    serial_subtractor #(.WIDTH(1), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start1), .A(a1), .B(b1), .bin(1'b0),
        .busy(busy1), .done(done1), .Y(y1), .borrow(borrow1)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitors: one pop per rising edge of done, so a done held by en=0 is consumed once.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done  = 1'b0;
            prev_done1 = 1'b0;
        end else begin
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("result_y", 32'(y), 32'(mon_e.y));
                    check_output("result_borrow", 32'(borrow), 32'(mon_e.br));
                end
            end
            if (done1 && !prev_done1) begin
                if (exp1_q.size() == 0) begin
                    check_output("w1_unexpected_done", 32'(done1), 32'd0);
                end else begin
                    mon_e1 = exp1_q.pop_front();
                    check_output("w1_y", 32'(y1), 32'(mon_e1.y));
                    check_output("w1_borrow", 32'(borrow1), 32'(mon_e1.br));
                end
            end
            prev_done  = done;
            prev_done1 = done1;
        end
    end

    // Returns just after the accepting edge, with the operands already scrambled.
    task automatic apply_stimulus(input logic [7:0] ai, input logic [7:0] bi, input logic bi_n,
                                  input logic [7:0] ey, input logic ebr);
        exp_t e;
        @(posedge clk); #1;
        a = ai; b = bi; bin = bi_n; start = 1'b1;
        e.y = ey; e.br = ebr;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ai; b = ai; bin = ~bi_n;
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!done && cycles < 50);
        if (!done) check_output({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    vec_t vecs[6];
    int   cyc;
    logic any_done;

    initial begin
        vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, y: 8'h02, br: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, y: 8'hFE, br: 1'b1};
        vecs[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, y: 8'hFF, br: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'h01, bin: 1'b1, y: 8'hFD, br: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, bin: 1'b1, y: 8'hFF, br: 1'b1};
        vecs[5] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, y: 8'h00, br: 1'b0};

        #3;
        check_output("reset_y", 32'(y), 32'd0);
        check_output("reset_borrow", 32'(borrow), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, each started right after the previous done (back-to-back).
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].y, vecs[i].br);
            check_output("busy_after_accept", 32'(busy), 32'd1);
            wait_done("vec", cyc);
            check_output("latency", 32'(cyc), 32'd4);
            check_output("busy_at_done", 32'(busy), 32'd0);
        end

        // en low for two cycles mid-run stretches the operation to 6 cycles.
        apply_stimulus(8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0);
        @(posedge clk); #1;
        en = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("busy_hold_en_low", 32'(busy), 32'd1);
        en = 1'b1;
        start = 1'b0;
        wait_done("en_stall", cyc);
        check_output("latency_en_stall", 32'(cyc + 3), 32'd6);
        en = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check_output("done_hold_en_low", 32'(done), 32'd1);
        end
        check_output("y_hold_en_low", 32'(y), 32'h4B);
        en = 1'b1;
        @(posedge clk); #1;
        check_output("done_one_cycle", 32'(done), 32'd0);

        // start while idle but disabled must be ignored.
        en = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("start_ignored_en_low", 32'(busy), 32'd0);
        start = 1'b0;
        en = 1'b1;
        @(posedge clk); #1;
        check_output("still_idle", 32'(busy), 32'd0);

        // start held through a run; mid-run operand change only feeds the next operation.
        a = 8'h20; b = 8'h01; bin = 1'b0; start = 1'b1;
        exp_q.push_back('{y: 8'h1F, br: 1'b0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 8'h40;
        exp_q.push_back('{y: 8'h3F, br: 1'b0});
        wait_done("held_first", cyc);
        check_output("held_first_latency", 32'(cyc), 32'd3);
        @(posedge clk); #1;
        check_output("back_to_back_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("held_second", cyc);
        check_output("held_second_latency", 32'(cyc), 32'd4);

        // Reset in the second RUN cycle aborts the operation immediately.
        @(posedge clk); #1;
        a = 8'hFF; b = 8'h00; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_output("abort_y", 32'(y), 32'd0);
        check_output("abort_borrow", 32'(borrow), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        any_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            any_done = any_done | done;
        end
        check_output("no_done_after_abort", 32'(any_done), 32'd0);
        check_output("y_after_abort", 32'(y), 32'd0);

        // The first edge after reset release accepts start.
        rst_n = 1'b0;
        #2;
        a = 8'h07; b = 8'h02; bin = 1'b0; start = 1'b1;
        exp_q.push_back('{y: 8'h05, br: 1'b0});
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_output("accept_first_edge", 32'(busy), 32'd1);
        wait_done("post_reset", cyc);
        check_output("post_reset_latency", 32'(cyc), 32'd4);

        // One-bit instance: all four operand pairs, done one cycle after acceptance.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a1 = 1'((i >> 1) & 1);
            b1 = 1'(i & 1);
            start1 = 1'b1;
            case (i)
                0: exp1_q.push_back('{y: 8'h00, br: 1'b0});
                1: exp1_q.push_back('{y: 8'h01, br: 1'b1});
                2: exp1_q.push_back('{y: 8'h01, br: 1'b0});
                default: exp1_q.push_back('{y: 8'h00, br: 1'b0});
            endcase
            @(posedge clk); #1;
            start1 = 1'b0;
            check_output("w1_busy", 32'(busy1), 32'd1);
            @(posedge clk); #1;
            check_output("w1_done", 32'(done1), 32'd1);
        end

        @(posedge clk); #1;
        check_output("scoreboard_drained", 32'(exp_q.size() + exp1_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
